// File: rtl/toggle_counter.sv
// Modulo-MODULUS up/down counter that exports per-bit toggle enables (t_vec) for a T-FF bank.
// count/wrap/load_err are registered; t_vec and tc are same-cycle combinational.
module toggle_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH-1:0] w_count_next;
  logic             w_load_ok;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;

  // Range check ahead of the register keeps out-of-range values unreachable.
  assign w_load_ok = ({1'b0, load_val} < (WIDTH+1)'(MODULUS));
  assign w_at_max  = (r_count == MAX_VAL);
  assign w_at_zero = (r_count == '0);
  assign w_tc      = en & ~clr & ~load & (up ? w_at_max : w_at_zero);

  always_comb begin
    w_count_next = r_count;
    if (clr) begin
      w_count_next = '0;
    end else if (load) begin
      w_count_next = w_load_ok ? load_val : MAX_VAL;
    end else if (en) begin
      if (up) begin
        w_count_next = w_at_max ? '0 : r_count + WIDTH'(1);
      end else begin
        w_count_next = w_at_zero ? MAX_VAL : r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_wrap     <= w_tc;
      r_load_err <= ~clr & load & ~w_load_ok;
    end
  end

  assign count    = r_count;
  assign t_vec    = r_count ^ w_count_next;
  assign tc       = w_tc;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_toggle_counter.sv
// Bench for toggle_counter: MODULUS=10 and MODULUS=256 instances share stimulus,
// an arithmetic reference model plus T-FF reconstruction is compared every negedge.
module tb_toggle_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] c10, t10, c256, t256;
  logic       tc10, w10, le10, tc256, w256, le256;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(8), .MODULUS(10)) dut10 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(c10), .t_vec(t10), .tc(tc10), .wrap(w10),
    .load_err(le10)
  );

  toggle_counter #(.WIDTH(8), .MODULUS(256)) dut256 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(c256), .t_vec(t256), .tc(tc256), .wrap(w256),
    .load_err(le256)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: modular arithmetic on plain integers.
  function automatic int nxt(input int c, input int m);
    if (clr) return 0;
    if (load) return (int'(load_val) < m) ? int'(load_val) : m - 1;
    if (en) return up ? (c + 1) % m : (c + m - 1) % m;
    return c;
  endfunction

  function automatic bit wraps(input int c, input int m);
    if (clr || load || !en) return 1'b0;
    return up ? (c + 1 >= m) : (c == 0);
  endfunction

  int m10 = 0, m256 = 0;
  bit mw10 = 0, mw256 = 0, me10 = 0, me256 = 0;
  logic [7:0] tff10 = 0, tff256 = 0, tv10_s = 0, tv256_s = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m10 <= 0; m256 <= 0; mw10 <= 0; mw256 <= 0; me10 <= 0; me256 <= 0;
      tff10 <= 0; tff256 <= 0;
    end else begin
      m10    <= nxt(m10, 10);
      m256   <= nxt(m256, 256);
      mw10   <= wraps(m10, 10);
      mw256  <= wraps(m256, 256);
      me10   <= !clr && load && int'(load_val) >= 10;
      me256  <= !clr && load && int'(load_val) >= 256;
      tff10  <= tff10 ^ tv10_s;
      tff256 <= tff256 ^ tv256_s;
    end
  end

  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tv10_s  <= 0;
      tv256_s <= 0;
    end else begin
      check("m10.count", c10, m10);
      check("m10.t_vec", t10, m10 ^ nxt(m10, 10));
      check("m10.tc", tc10, wraps(m10, 10));
      check("m10.wrap", w10, mw10);
      check("m10.load_err", le10, me10);
      check("m10.tff", tff10, c10);
      check("m256.count", c256, m256);
      check("m256.t_vec", t256, m256 ^ nxt(m256, 256));
      check("m256.tc", tc256, wraps(m256, 256));
      check("m256.wrap", w256, mw256);
      check("m256.load_err", le256, me256);
      check("m256.tff", tff256, c256);
      tv10_s  <= t10;
      tv256_s <= t256;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

  initial begin
    #1;
    check("reset.count", c256, 0);
    check("reset.wrap", w256, 0);
    check("reset.load_err", le256, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset asserted between edges with a nonzero count
    load = 1; load_val = 8'h37;
    tick();
    load = 0;
    check("load37.count256", c256, 8'h37);
    check("load37.count10", c10, 9);
    check("load37.load_err10", le10, 1);
    #1 reset_n = 1'b0;
    #1;
    check("midreset.count256", c256, 0);
    check("midreset.count10", c10, 0);
    check("midreset.wrap10", w10, 0);
    check("midreset.load_err10", le10, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Count up through the modulus
    clr = 1;
    tick();
    clr = 0; en = 1; up = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up.count", c10, seq[i]);
      check("up.wrap", w10, (i == 9) ? 1 : 0);
      check("up.tc", tc10, (seq[i] == 9) ? 1 : 0);
    end

    // Count down from zero
    clr = 1;
    tick();
    clr = 0; up = 0;
    #1;
    check("down.tvec_at0", t10, 8'h09);
    check("down.tc_at0", tc10, 1);
    tick();
    check("down.count9", c10, 9);
    check("down.tvec_at9", t10, 8'h01);
    check("down.wrap", w10, 1);
    tick();
    check("down.count8", c10, 8);
    en = 0;

    // clr beats load and en on the same edge
    load = 1; load_val = 8'd5;
    tick();
    check("pri.count5", c10, 5);
    clr = 1; load = 1; en = 1; up = 1; load_val = 8'd7;
    #1;
    check("pri.tvec", t10, 8'h05);
    check("pri.tc", tc10, 0);
    tick();
    check("pri.count", c10, 0);
    check("pri.wrap", w10, 0);
    check("pri.load_err", le10, 0);
    clr = 0; en = 0;

    // Out-of-range load saturates to MODULUS-1 and flags once
    load_val = 8'd12;
    tick();
    check("oor.count", c10, 9);
    check("oor.load_err", le10, 1);
    check("oor.count256", c256, 12);
    load_val = 8'd3;
    tick();
    check("inr.count", c10, 3);
    check("inr.load_err", le10, 0);
    load = 0;
    tick();
    check("hold.count", c10, 3);
    check("hold.tvec", t10, 0);

    // Random en/up/clr/load mix, checked by the per-cycle compare
    for (int i = 0; i < 1000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1) != 0;
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 8'($urandom_range(0, 255));
      tick();
    end
    en = 0; clr = 0; load = 0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
